// File: rtl/sm3_arb_pkg.sv
// sm3_arb_pkg
//   Shared types and constants for the SM3 request arbiter slice.
//   - arb_st_t   : arbiter FSM state encoding
//   - SM3_RES_W  : width of a compression result
//   - SM3_ARB_DW : default message beat width, follows the core build define
//   - SM3_ARB_BW : default byte-valid width derived from SM3_ARB_DW
//   - rr_inc()   : wrap-around increment used for the round-robin pointer
package sm3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FEED     = 2'd1,
        WAIT_RES = 2'd2
    } arb_st_t;

    localparam int SM3_RES_W = 256;

    // The core is built either with a 32-bit or a 64-bit input stream
    // (sm3_cfg.v defines SM3_INPT_DW_32 or SM3_INPT_DW_64); the arbiter
    // defaults track whichever build is selected, 64 bits otherwise.
`ifdef SM3_INPT_DW_32
    localparam int SM3_ARB_DW = 32;
`else
    localparam int SM3_ARB_DW = 64;
`endif
    localparam int SM3_ARB_BW = SM3_ARB_DW / 8;

    // Next requester index after id, wrapping at n.
    function automatic int unsigned rr_inc(input int unsigned id, input int unsigned n);
        return ((id + 1) >= n) ? 0 : (id + 1);
    endfunction

endpackage

// File: rtl/sm3_req_arbiter_rr_pick.sv
// sm3_rr_pick
//   Combinational round-robin picker. Returns the first set bit of req
//   searching upward from rr_ptr with wrap-around.
//   Ports:
//     req    in  N_REQ  request vector
//     rr_ptr in  ID_W   index with highest priority this cycle
//     hit    out 1      at least one request is set
//     idx    out ID_W   index of the chosen request (0 when hit is low)
module sm3_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             hit,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] cand;

    // Walk the candidates in priority order; the first request found wins.
    // The modulo keeps the search correct for non-power-of-two N_REQ.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned off = 0; off < 32'(N_REQ); off++) begin
            cand = ID_W'((32'(rr_ptr) + off) % 32'(N_REQ));
            if (!hit && req[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/sm3_req_arbiter.sv
// sm3_req_arbiter
//   Shares one sm3_core_top between N_REQ message requesters. Arbitration is
//   round-robin at message granularity: a requester owns the core from its
//   first accepted beat until the compression result for that message has
//   been returned to it as a one-cycle pulse.
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     req_vld/req_d/
//     req_vld_byte/req_lst     per-requester beat stream (slice i = requester i)
//     req_rdy                  per-requester beat accept
//     rsp_vld                  one-hot, one-cycle result pulse to the owner
//     rsp_res                  result, held until the next result
//     core_msg_inpt_*          beat stream towards the core
//     core_cmprss_otpt_*       result from the core
//     busy                     arbiter is not idle
//     grant_id                 current or most recent owner
//     err_unexp_res            sticky: a core result arrived while not waiting
module sm3_req_arbiter
    import sm3_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = SM3_ARB_DW,
    parameter int BW    = DW / 8,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic [N_REQ-1:0]     req_vld,
    input  logic [N_REQ*DW-1:0]  req_d,
    input  logic [N_REQ*BW-1:0]  req_vld_byte,
    input  logic [N_REQ-1:0]     req_lst,
    output logic [N_REQ-1:0]     req_rdy,

    output logic [N_REQ-1:0]     rsp_vld,
    output logic [SM3_RES_W-1:0] rsp_res,

    output logic [DW-1:0]        core_msg_inpt_d,
    output logic [BW-1:0]        core_msg_inpt_vld_byte,
    output logic                 core_msg_inpt_vld,
    output logic                 core_msg_inpt_lst,
    input  logic                 core_msg_inpt_rdy,
    input  logic                 core_cmprss_otpt_vld,
    input  logic [SM3_RES_W-1:0] core_cmprss_otpt_res,

    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 err_unexp_res
);

    arb_st_t         state;
    arb_st_t         state_nxt;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_q;
    logic            pick_hit;
    logic [ID_W-1:0] pick_idx;
    logic [N_REQ-1:0] grant_hot;
    logic            res_take;
    logic            res_unexp;

    logic [DW-1:0]   d_arr  [N_REQ];
    logic [BW-1:0]   vb_arr [N_REQ];

    // Flat requester buses split into per-requester lanes for the mux.
    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign d_arr[g]  = req_d[g*DW +: DW];
        assign vb_arr[g] = req_vld_byte[g*BW +: BW];
    end

    sm3_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (req_vld),
        .rr_ptr (rr_ptr),
        .hit    (pick_hit),
        .idx    (pick_idx)
    );

    assign grant_hot = N_REQ'(1) << grant_q;
    assign res_take  = (state == WAIT_RES) && core_cmprss_otpt_vld;
    assign res_unexp = (state != WAIT_RES) && core_cmprss_otpt_vld;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the combinational stream path. The core side sees the
    // owner's stream only in FEED; everything is forced to zero elsewhere so
    // stale requester data never reaches the core.
    always_comb begin
        state_nxt              = state;
        req_rdy                = '0;
        core_msg_inpt_d        = '0;
        core_msg_inpt_vld_byte = '0;
        core_msg_inpt_vld      = 1'b0;
        core_msg_inpt_lst      = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_hit) begin
                    state_nxt = FEED;
                end
            end

            FEED: begin
                core_msg_inpt_d        = d_arr[grant_q];
                core_msg_inpt_vld_byte = vb_arr[grant_q];
                core_msg_inpt_vld      = req_vld[grant_q];
                core_msg_inpt_lst      = req_lst[grant_q];
                req_rdy[grant_q]       = core_msg_inpt_rdy;
                // A dropped req_vld is only a bubble; the grant is kept
                // until the last beat is actually handed over.
                if (req_vld[grant_q] && core_msg_inpt_rdy && req_lst[grant_q]) begin
                    state_nxt = WAIT_RES;
                end
            end

            WAIT_RES: begin
                if (core_cmprss_otpt_vld) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant, round-robin pointer and result path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q       <= '0;
            rr_ptr        <= '0;
            rsp_vld       <= '0;
            rsp_res       <= '0;
            err_unexp_res <= 1'b0;
        end else begin
            rsp_vld <= '0;

            if ((state == IDLE) && pick_hit) begin
                grant_q <= pick_idx;
            end

            // The pointer moves only when a message completes, so a
            // requester that re-requests right away is ordered behind every
            // other pending requester.
            if (res_take) begin
                rsp_vld <= grant_hot;
                rsp_res <= core_cmprss_otpt_res;
                rr_ptr  <= ID_W'(rr_inc(32'(grant_q), 32'(N_REQ)));
            end

            if (res_unexp) begin
                err_unexp_res <= 1'b1;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign grant_id = grant_q;

endmodule

// File: doc/sm3_req_arbiter.md
Name: sm3_req_arbiter

Overview:
- Shares one sm3_core_top instance (SM3_INPT_DW_64 build) between N_REQ independent message requesters.
- Arbitration is round-robin and message-granular. A grant is held from the first accepted beat until the compression result for that message has been returned.
- Sits between requester-side streaming ports and the core's sm3_if signals (msg_inpt_*, cmprss_otpt_*).
- Routes the 256-bit result back to the owning requester as a one-cycle pulse.

Parameters:
- N_REQ, 4, number of requesters; 2..8.
- DW, 64, message beat width in bits; must match the core build (32 or 64).
- BW, DW/8, byte-valid width (derived; do not override).
- ID_W, $clog2(N_REQ), width of the requester index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  N_REQ  per-requester beat valid.
- req_d  in  N_REQ*DW  per-requester beat data; requester i occupies slice [i*DW +: DW].
- req_vld_byte  in  N_REQ*BW  per-requester byte valids; same slicing rule.
- req_lst  in  N_REQ  last beat of the message.
- req_rdy  out  N_REQ  beat accepted when req_vld[i] && req_rdy[i].
- rsp_vld  out  N_REQ  one-hot, one-cycle result pulse.
- rsp_res  out  256  hash result; valid when any rsp_vld bit is set.
- core_msg_inpt_d  out  DW  to core msg_inpt_d.
- core_msg_inpt_vld_byte  out  BW  to core msg_inpt_vld_byte.
- core_msg_inpt_vld  out  1  to core msg_inpt_vld.
- core_msg_inpt_lst  out  1  to core msg_inpt_lst.
- core_msg_inpt_rdy  in  1  from core msg_inpt_rdy.
- core_cmprss_otpt_vld  in  1  from core cmprss_otpt_vld.
- core_cmprss_otpt_res  in  256  from core cmprss_otpt_res.
- busy  out  1  state != IDLE.
- grant_id  out  ID_W  current or most recent owner.
- err_unexp_res  out  1  sticky flag: a result arrived outside WAIT_RES.

Behaviour:
Reset (asynchronous, rst_n low):
- State goes to IDLE. rr_ptr, grant_id, rsp_vld, rsp_res, err_unexp_res and busy are all cleared to 0.
- The core shares the same rst_n, so reset mid-message aborts both sides cleanly. No partial state survives.

FSM states: IDLE, FEED, WAIT_RES.

IDLE:
- All req_rdy = 0; core_msg_inpt_vld = 0.
- If any req_vld is set, pick the first set bit searching from rr_ptr upward with wrap-around. Register it in grant_id and go to FEED on the next edge.
- Arbitration latency: 1 cycle, so the first beat is accepted no earlier than cycle 2 after req_vld rises.

FEED:
- Combinational mux from requester grant_id to the core: d, vld_byte, vld, lst.
- req_rdy[grant_id] = core_msg_inpt_rdy; all other req_rdy = 0.
- A requester may drop req_vld mid-message; this produces bubbles and the grant is held.
- On core_msg_inpt_vld && core_msg_inpt_rdy && core_msg_inpt_lst, go to WAIT_RES.

WAIT_RES:
- All req_rdy = 0; core_msg_inpt_vld = 0.
- On core_cmprss_otpt_vld: register core_cmprss_otpt_res into rsp_res, set rsp_vld[grant_id] = 1 for exactly one cycle (1-cycle registered latency), set rr_ptr = grant_id+1 (mod N_REQ), and go to IDLE.

Core output gating:
- Outside FEED, core_msg_inpt_d, core_msg_inpt_vld_byte and core_msg_inpt_lst are driven to 0.

Result-path rules:
- rsp_res holds its value until the next result.
- A core_cmprss_otpt_vld seen in IDLE or FEED is dropped and sets err_unexp_res. It does not change state.

Simultaneous events:
- A result pulse in WAIT_RES and new req_vld in the same cycle: the FSM goes to IDLE. The new arbitration uses the updated rr_ptr in the following cycle.
- Back-to-back messages from one requester alternate fairly with any other pending requesters.

Fairness:
- With all requesters continuously pending, grants rotate 0,1,..,N_REQ-1,0.
- A single pending requester is re-granted immediately after its own result.

Decomposition:
- Package sm3_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, FEED, WAIT_RES} arb_st_t;
  - localparam SM3_RES_W = 256.
  - the DW/BW defaults tied to the SM3_INPT_DW_* defines from sm3_cfg.v.
- Sub-module sm3_rr_pick: combinational round-robin picker. Inputs are req vector and rr_ptr; outputs are hit and idx. Parameterised on N_REQ.

Test Plan:
1. Reset mid-FEED:
   - Stimulus: a 3-beat message from req1; assert rst_n low after beat 2.
   - Required: all outputs are 0 immediately (asynchronous). After release, the state is IDLE and no rsp_vld fires.
2. Single message "abc" from req0:
   - Stimulus: one beat, d = 64'h6162_6300_0000_0000, vld_byte = 8'hE0, lst = 1.
   - Required: rsp_vld = 4'b0001 for 1 cycle.
   - Required: rsp_res = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0.
3. All four requesters pending with the "abc" beat:
   - Required: grant_id sequence is 0,1,2,3.
   - Required: each receives the result above exactly once, and req_rdy is never set for a non-owner.
4. req2 sends a 2-beat message with req_vld deasserted for 5 cycles between beats:
   - Required: the grant is held and core_msg_inpt_vld = 0 during the gap.
   - Required: req0 asserting req_vld during the gap gets no req_rdy until req2's rsp_vld.
5. Force core_cmprss_otpt_vld high for 1 cycle while in IDLE:
   - Required: err_unexp_res = 1 and stays 1, rsp_vld stays 0, state stays IDLE.
6. Result and new request in the same cycle:
   - Stimulus: req3's result arrives in WAIT_RES while req3 and req0 are both pending.
   - Required: the next grant goes to req0 (rr_ptr wraps), then req3.
